// File: rtl/apb_test_pkg.sv
// Shared definitions for the APB test completer: register offsets, FSM states,
// device identity default and the byte-lane merge helper.
package apb_test_pkg;

   localparam logic [31:0] DEVICE_ID_DEFAULT = 32'h4C55_4C5A;

   localparam logic [9:0] OFF_ID          = 10'h000;
   localparam logic [9:0] OFF_SCRATCH0    = 10'h004;
   localparam logic [9:0] OFF_SCRATCH1    = 10'h008;
   localparam logic [9:0] OFF_WAIT_CFG    = 10'h00C;
   localparam logic [9:0] OFF_XFER_COUNT  = 10'h010;
   localparam logic [9:0] OFF_ERR_COUNT   = 10'h014;
   localparam logic [9:0] OFF_CYCLE_COUNT = 10'h018;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   // Replace only the byte lanes whose strobe bit is set.
   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/apb_test_completer.sv
// APB completer with scratch registers, programmable wait states and
// transfer/error/cycle counters, intended as a bus test target.
module apb_test_completer
   import apb_test_pkg::*;
#(
   parameter logic [31:0] DEVICE_ID    = DEVICE_ID_DEFAULT,
   parameter logic [3:0]  DEFAULT_WAIT = 4'd0
) (
   input  logic        pclk,
   input  logic        preset_n,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [9:0]  paddr,
   input  logic [31:0] pwdata,
   input  logic [3:0]  pstrb,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr
);

   apb_state_e  state_r, next_state_s;
   logic [3:0]  wait_cnt_r;
   logic [3:0]  wait_cfg_r;
   logic [31:0] scratch0_r, scratch1_r;
   logic [31:0] xfer_cnt_r, err_cnt_r, cycle_cnt_r;
   logic        pready_r, pslverr_r;
   logic [31:0] prdata_r;

   logic        setup_s, complete_s, abort_s, raise_s;
   logic [31:0] rd_data_s;
   logic        hit_s, ro_s, err_s;

   // Address decode: read mux plus error classification of the current access.
   always_comb begin
      rd_data_s = 32'h0000_0000;
      hit_s     = 1'b1;
      ro_s      = 1'b0;
      case (paddr)
         OFF_ID: begin
            rd_data_s = DEVICE_ID;
            ro_s      = 1'b1;
         end
         OFF_SCRATCH0:    rd_data_s = scratch0_r;
         OFF_SCRATCH1:    rd_data_s = scratch1_r;
         OFF_WAIT_CFG:    rd_data_s = {28'h000_0000, wait_cfg_r};
         OFF_XFER_COUNT: begin
            rd_data_s = xfer_cnt_r;
            ro_s      = 1'b1;
         end
         OFF_ERR_COUNT: begin
            rd_data_s = err_cnt_r;
            ro_s      = 1'b1;
         end
         OFF_CYCLE_COUNT: begin
            rd_data_s = cycle_cnt_r;
            ro_s      = 1'b1;
         end
         default:         hit_s = 1'b0;
      endcase
      err_s = ~hit_s | (ro_s & pwrite);
   end

   // Next-state logic and transfer event strobes.
   always_comb begin
      next_state_s = state_r;
      setup_s      = 1'b0;
      complete_s   = 1'b0;
      abort_s      = 1'b0;
      raise_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (psel && !penable) begin
               next_state_s = ST_ACCESS;
               setup_s      = 1'b1;
               raise_s      = (wait_cfg_r == 4'd0);
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (!psel) begin
               next_state_s = ST_IDLE;
               abort_s      = 1'b1;
            end else if (penable && pready_r) begin
               next_state_s = ST_IDLE;
               complete_s   = 1'b1;
            end else begin
               next_state_s = ST_ACCESS;
               raise_s      = !pready_r && (wait_cnt_r == 4'd1);
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Response, register file and counters; read data is frozen when pready rises.
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         wait_cnt_r  <= 4'd0;
         wait_cfg_r  <= DEFAULT_WAIT;
         scratch0_r  <= 32'h0000_0000;
         scratch1_r  <= 32'h0000_0000;
         xfer_cnt_r  <= 32'h0000_0000;
         err_cnt_r   <= 32'h0000_0000;
         cycle_cnt_r <= 32'h0000_0000;
         pready_r    <= 1'b0;
         pslverr_r   <= 1'b0;
         prdata_r    <= 32'h0000_0000;
      end else begin
         cycle_cnt_r <= cycle_cnt_r + 32'd1;
         if (setup_s) begin
            wait_cnt_r <= wait_cfg_r;
         end else if ((state_r == ST_ACCESS) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
         end
         if (raise_s) begin
            pready_r  <= 1'b1;
            pslverr_r <= err_s;
            prdata_r  <= (err_s || pwrite) ? 32'h0000_0000 : rd_data_s;
         end else if (complete_s || abort_s) begin
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= 32'h0000_0000;
         end
         if (complete_s) begin
            xfer_cnt_r <= xfer_cnt_r + 32'd1;
            if (pslverr_r && (err_cnt_r != 32'hFFFF_FFFF)) begin
               err_cnt_r <= err_cnt_r + 32'd1;
            end
            if (pwrite && !pslverr_r) begin
               case (paddr)
                  OFF_SCRATCH0: scratch0_r <= apply_strb(scratch0_r, pwdata, pstrb);
                  OFF_SCRATCH1: scratch1_r <= apply_strb(scratch1_r, pwdata, pstrb);
                  OFF_WAIT_CFG: begin
                     if (pstrb[0]) begin
                        wait_cfg_r <= pwdata[3:0];
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign prdata  = prdata_r;
   assign pready  = pready_r;
   assign pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_test_completer.sv
// Directed self-checking bench for apb_test_completer: register access,
// wait states, error responses, counters, abort and mid-transfer reset.
module tb_apb_test_completer;

   logic        pclk;
   logic        preset_n;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [9:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int n_cmp = 0;
   int n_bad = 0;

   apb_test_completer dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .pstrb    (pstrb),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One APB transfer starting just after a rising edge; leaves psel high for back-to-back use.
   task automatic xfer(input logic wr, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic er,
                       output int waits);
      bit done;
      done  = 1'b0;
      waits = 0;
      rd    = 32'h0;
      er    = 1'b0;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(posedge pclk); #1 penable = 1'b1;
      for (int k = 0; k < 32 && !done; k++) begin
         @(negedge pclk);
         if (pready === 1'b1) begin
            rd   = prdata;
            er   = pslverr;
            done = 1'b1;
         end else begin
            waits++;
         end
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $error("FAIL timeout: observed no pready expected pready within 32 cycles");
      end
      @(posedge pclk); #1;
   endtask

   task automatic rd_chk(input string tag, input logic [9:0] a, input logic [31:0] exp_d,
                         input logic exp_e, input int exp_w);
      logic [31:0] rd;
      logic        er;
      int          w;
      xfer(1'b0, a, 32'h0, 4'h0, rd, er, w);
      check({tag, "_data"}, rd, exp_d);
      check({tag, "_err"}, {31'h0, er}, {31'h0, exp_e});
      check({tag, "_waits"}, w, exp_w);
   endtask

   task automatic wr_chk(input string tag, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic exp_e, input int exp_w);
      logic [31:0] rd;
      logic        er;
      int          w;
      xfer(1'b1, a, d, s, rd, er, w);
      check({tag, "_data"}, rd, 32'h0);
      check({tag, "_err"}, {31'h0, er}, {31'h0, exp_e});
      check({tag, "_waits"}, w, exp_w);
   endtask

   task automatic idle();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge pclk); #1;
   endtask

   initial begin
      logic [31:0] c0, c1, rd;
      logic        er;
      int          w;

      preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 10'h0; pwdata = 32'h0; pstrb = 4'h0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("rst_pready", {31'h0, pready}, 32'h0);
      check("rst_prdata", prdata, 32'h0);
      check("rst_pslverr", {31'h0, pslverr}, 32'h0);
      @(posedge pclk); #1 preset_n = 1'b1;

      rd_chk("id", 10'h000, 32'h4C55_4C5A, 1'b0, 0);
      idle();
      @(negedge pclk);
      check("post_done_pready", {31'h0, pready}, 32'h0);
      check("post_done_prdata", prdata, 32'h0);
      @(posedge pclk); #1;

      // Strobed writes and pstrb=0
      wr_chk("wr_s0_strb", 10'h004, 32'hDEAD_BEEF, 4'b0101, 1'b0, 0);
      rd_chk("rd_s0_strb", 10'h004, 32'h00AD_00EF, 1'b0, 0);
      wr_chk("wr_s1", 10'h008, 32'hCAFE_F00D, 4'b1111, 1'b0, 0);
      wr_chk("wr_s1_nostrb", 10'h008, 32'h1234_5678, 4'b0000, 1'b0, 0);
      rd_chk("rd_s1", 10'h008, 32'hCAFE_F00D, 1'b0, 0);

      // Wait states: the WAIT_CFG write itself completes with zero waits
      wr_chk("wr_wait3", 10'h00C, 32'hFFFF_FFF3, 4'b1111, 1'b0, 0);
      rd_chk("rd_wait3", 10'h00C, 32'h0000_0003, 1'b0, 3);
      rd_chk("rd_s1_w3", 10'h008, 32'hCAFE_F00D, 1'b0, 3);

      // Error responses
      wr_chk("wr_ro", 10'h010, 32'hFFFF_FFFF, 4'b1111, 1'b1, 3);
      rd_chk("rd_unmapped", 10'h020, 32'h0, 1'b1, 3);
      rd_chk("rd_misalign", 10'h005, 32'h0, 1'b1, 3);
      rd_chk("err_count", 10'h014, 32'd3, 1'b0, 3);
      rd_chk("xfer_count", 10'h010, 32'd13, 1'b0, 3);

      // CYCLE_COUNT spacing of back-to-back reads: setup + 4 access cycles
      xfer(1'b0, 10'h018, 32'h0, 4'h0, c0, er, w);
      xfer(1'b0, 10'h018, 32'h0, 4'h0, c1, er, w);
      check("cycle_diff_w3", c1 - c0, 32'd5);
      wr_chk("wr_wait0", 10'h00C, 32'h0, 4'b0001, 1'b0, 3);
      xfer(1'b0, 10'h018, 32'h0, 4'h0, c0, er, w);
      xfer(1'b0, 10'h018, 32'h0, 4'h0, c1, er, w);
      check("cycle_diff_w0", c1 - c0, 32'd2);
      wr_chk("wr_wait2", 10'h00C, 32'h2, 4'b0001, 1'b0, 0);

      // Abort: psel dropped during the access phase of a wait-stated write
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h004;
      pwdata = 32'h1234_5678; pstrb = 4'b1111;
      @(posedge pclk); #1 penable = 1'b1;
      @(negedge pclk);
      check("abort_pready_a", {31'h0, pready}, 32'h0);
      @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge pclk);
         check("abort_pready_b", {31'h0, pready}, 32'h0);
      end
      @(posedge pclk); #1;
      rd_chk("abort_s0", 10'h004, 32'h00AD_00EF, 1'b0, 2);
      rd_chk("abort_xfer", 10'h010, 32'd21, 1'b0, 2);

      // One-cycle reset during a wait-stated write
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h008;
      pwdata = 32'h1111_1111; pstrb = 4'b1111;
      @(posedge pclk); #1 penable = 1'b1;
      @(negedge pclk);
      @(posedge pclk); #1 preset_n = 1'b0; psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("midrst_pready", {31'h0, pready}, 32'h0);
      @(posedge pclk); #1 preset_n = 1'b1;
      rd_chk("midrst_xfer", 10'h010, 32'd0, 1'b0, 0);
      rd_chk("midrst_wait", 10'h00C, 32'd0, 1'b0, 0);
      rd_chk("midrst_s0", 10'h004, 32'd0, 1'b0, 0);
      rd_chk("midrst_s1", 10'h008, 32'd0, 1'b0, 0);
      rd_chk("midrst_err", 10'h014, 32'd0, 1'b0, 0);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
